// File: rtl/counter5_pkg.sv
// Shared definitions for the mod-5 sequence checker: code limits, FSM state
// type and the modulo-5 successor function.
package counter5_pkg;

  localparam logic [2:0] C5_MOD      = 3'd5;
  localparam logic [2:0] C5_MAX_CODE = 3'd4;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } c5_state_e;

  // Any result at or beyond the modulus folds to 0, so codes 5..7 never escape.
  function automatic logic [2:0] c5_next(input logic [2:0] v);
    logic [2:0] inc;
    inc = v + 3'd1;
    return (inc >= C5_MOD || inc == 3'd0) ? 3'd0 : inc;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low reset; sticks at all-ones.
module sat_counter #(
  parameter int unsigned width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [width-1:0] count
);

  logic [width-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/counter5_checker.sv
// Checks that a sampled 3-bit stream follows 0,1,2,3,4,0,...; HUNT/LOCK FSM.
// Build macro COUNTER5_CHK_ERRCNT_EN adds the saturating err_count output.
module counter5_checker
  import counter5_pkg::*;
#(
  parameter int unsigned MISS_LIMIT = 2,
  parameter int unsigned ERRW       = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [2:0]      cnt_in,
  output logic            locked,
  output logic            err,
  output logic            illegal,
  output logic            wrap
`ifdef COUNTER5_CHK_ERRCNT_EN
  ,
  output logic [ERRW-1:0] err_count
`endif
);

  localparam logic [2:0] MISS_LIM3 = MISS_LIMIT[2:0];

  if (MISS_LIMIT < 1 || MISS_LIMIT > 7 || ERRW < 1) begin : g_param_err
    $error("counter5_checker: MISS_LIMIT must be 1..7 and ERRW >= 1");
  end

  c5_state_e  r_state, w_state_nx;
  logic [2:0] r_exp, w_exp_nx;
  logic [2:0] r_miss, w_miss_nx;
  logic [2:0] w_miss_inc;
  logic       r_err, w_err_nx;
  logic       r_illegal, w_illegal_nx;
  logic       r_wrap, w_wrap_nx;
  logic       w_code_bad;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= HUNT;
      r_exp     <= '0;
      r_miss    <= '0;
      r_err     <= 1'b0;
      r_illegal <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_exp     <= w_exp_nx;
      r_miss    <= w_miss_nx;
      r_err     <= w_err_nx;
      r_illegal <= w_illegal_nx;
      r_wrap    <= w_wrap_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_exp_nx     = r_exp;
    w_miss_nx    = r_miss;
    w_err_nx     = 1'b0;
    w_illegal_nx = 1'b0;
    w_wrap_nx    = 1'b0;
    w_code_bad   = (cnt_in > C5_MAX_CODE);
    w_miss_inc   = r_miss + 3'd1;

    if (in_valid) begin
      w_illegal_nx = w_code_bad;
      unique case (r_state)
        HUNT: begin
          if (cnt_in == 3'd0) begin
            w_state_nx = LOCK;
            w_exp_nx   = 3'd1;
            w_miss_nx  = '0;
          end
        end
        LOCK: begin
          if (cnt_in == r_exp) begin
            w_exp_nx  = c5_next(r_exp);
            w_miss_nx = '0;
            w_wrap_nx = (cnt_in == C5_MAX_CODE);
          end else begin
            w_err_nx = 1'b1;
            // Illegal codes cannot seed the sequence, so advance our own guess.
            w_exp_nx = w_code_bad ? c5_next(r_exp) : c5_next(cnt_in);
            if (w_miss_inc >= MISS_LIM3) begin
              w_state_nx = HUNT;
              w_miss_nx  = '0;
            end else begin
              w_miss_nx = w_miss_inc;
            end
          end
        end
      endcase
    end
  end

  assign locked  = (r_state == LOCK);
  assign err     = r_err;
  assign illegal = r_illegal;
  assign wrap    = r_wrap;

`ifdef COUNTER5_CHK_ERRCNT_EN
  // Fed by the next-state err so the count moves on the same edge as the pulse.
  sat_counter #(
    .width(ERRW)
  ) u_err_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (w_err_nx),
    .count(err_count)
  );
`endif

endmodule
